mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
Initiator-side load/store unit that drives the core data-memory bus (mem_addr, mem_wdata, mem_wmask, mem_rstrb, mem_rdata, mem_rbusy, mem_wbusy) on behalf of the RV32 execute stage. It accepts one load/store request at a time over a valid/ready handshake. It generates byte-aligned write masks and replicated write data, strobes reads, waits out memory busy, and returns sign- or zero-extended load data with a single-cycle response pulse. Misaligned, illegal and timed-out accesses are reported through resp_err.

Parameters:
TIMEOUT_CYCLES, 0, maximum number of WAIT cycles before the access is abandoned with resp_err. 0 disables the timeout.
TO_WIDTH, 8, width of the wait counter. TIMEOUT_CYCLES must be less than 2**TO_WIDTH.

Ports:
clk  in  1  system clock, all logic on posedge.
reset  in  1  synchronous, active-low reset.
req_valid  in  1  request present.
req_ready  out  1  unit idle and able to accept a request.
req_we  in  1  1 = store, 0 = load.
req_funct3  in  3  RV32 load/store funct3.
req_addr  in  32  byte address.
req_wdata  in  32  store data in the low bits (rs2).
resp_valid  out  1  one-cycle completion pulse.
resp_rdata  out  32  extended load data; 0 for stores and errors.
resp_err  out  1  valid with resp_valid: misaligned, illegal funct3, or timeout.
mem_addr  out  32  word-aligned address {addr[31:2],2'b00}.
mem_wdata  out  32  replicated store data.
mem_wmask  out  4  byte write enables, asserted for exactly one cycle.
mem_rstrb  out  1  read strobe, asserted for exactly one cycle.
mem_rdata  in  32  read data from memory.
mem_rbusy  in  1  read not yet complete.
mem_wbusy  in  1  write not yet complete.

Behaviour:
- Reset (reset=0 at a posedge): state goes to IDLE and every output is 0, including req_ready. req_ready rises on the first cycle after reset is released.
- All outputs are registered.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch we, funct3, addr and wdata.
  - If illegal or misaligned, go to RESP with err=1 and perform no memory activity.
  - Otherwise go to ISSUE.
- Illegal funct3:
  - Loads: 011, 110, 111 are illegal.
  - Stores: any value other than 000, 001, 010 is illegal.
- Misaligned:
  - Halfword access with addr[0]=1.
  - Word access with addr[1:0]!=0.
- ISSUE (1 cycle):
  - mem_addr is driven and held until the unit returns to IDLE.
  - Load: mem_rstrb=1.
  - Store: mem_wmask and mem_wdata are driven.
  - Next state is WAIT; mem_rstrb and mem_wmask drop to 0.
- Store data and masks (off = addr[1:0]):
  - SB: wdata = {4{b}}, mask = 0001<<off.
  - SH: wdata = {2{h}}, mask = 0011<<off.
  - SW: wdata unchanged, mask = 1111.
- WAIT:
  - Load: when mem_rbusy=0, capture mem_rdata>>(8*off), extend per funct3 (LB/LH sign, LBU/LHU zero, LW none), then go to RESP.
  - Store: when mem_wbusy=0, go to RESP.
  - The wait counter increments each cycle busy is high. If TIMEOUT_CYCLES>0 and the count reaches TIMEOUT_CYCLES, go to RESP with err=1 and rdata=0.
- RESP (1 cycle): resp_valid=1 with resp_rdata and resp_err, then return to IDLE. resp_valid is 0 in every other state.
- Zero-wait latency:
  - Request accepted at cycle 0.
  - Strobe or mask at cycle 1.
  - resp_valid at cycle 3.
  - req_ready high again at cycle 4.
  - Error path: resp_valid at cycle 1.
- req_valid outside IDLE is ignored; the requester must hold it until the handshake completes.
- Reset during ISSUE: the mask or strobe already present at that edge is sampled by memory, so the write lands. No response is produced and outputs clear.
- Reset during WAIT or RESP: the access is dropped with no resp_valid.
- Counter width is TO_WIDTH; the counter saturates and clears when the unit enters ISSUE.

Decomposition:
- Package rv32_mem_pkg holds:
  - funct3 constants: F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - state encoding.
  - Combinational helper functions for legality and alignment.
- Sub-module mem_align (combinational) holds:
  - store data replication and mask generation.
  - load shift and extension.
  - misalignment detection.
- The FSM, counter and registers stay in mem_access_unit.

Test Plan:
1. Memory word[4]=0xDEADBEEF, zero-wait, LW addr 0x10 -> cycle 1: mem_rstrb=1, mem_addr=0x10; cycle 3: resp_valid=1, rdata=0xDEADBEEF, err=0.
2. Word at 0x10 = 0x80FF1234:
   - LB 0x13 -> 0xFFFFFF80.
   - LBU 0x13 -> 0x00000080.
   - LH 0x12 -> 0xFFFF80FF.
   - LHU 0x10 -> 0x00001234.
3. Stores:
   - SB addr 0x21, wdata 0x000000AB -> one cycle of mask=0010, wdata=0xABABABAB.
   - SH addr 0x22, wdata 0x1234 -> mask=1100, wdata=0x12341234.
   - Each with resp_valid at cycle 3.
4. Illegal and misaligned:
   - LW 0x06 -> resp_valid and resp_err at cycle 1, mem_rstrb never asserts.
   - Store with funct3=011 -> same, mem_wmask stays 0000.
5. Busy and timeout:
   - mem_rbusy high for 3 cycles after the strobe -> resp_valid one cycle after rbusy falls, req_ready low throughout.
   - TIMEOUT_CYCLES=4 with rbusy stuck high -> resp_err=1, rdata=0 after 4 WAIT cycles.
6. Reset: drive reset=0 during WAIT of a load -> next cycle all outputs 0, no resp_valid; a new LW issued after reset completes normally.

Source files
------------

// File: rtl/rv32_mem_pkg.sv
// Shared definitions for the RV32 load/store unit: funct3 encodings, the
// controller state type and combinational legality/alignment helpers.
package rv32_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // Stores only support B/H/W; loads additionally allow the unsigned forms.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    if (we) begin
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    end
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  // size is funct3[1:0]: 00 byte, 01 halfword, 10 word.
  function automatic logic addr_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b01:   return off[0];
      2'b10:   return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational data alignment for the load/store unit.
//   st_size_i/st_off_i/st_wdata_i : incoming store request -> replicated data
//                                   st_wdata_o and byte mask st_wmask_o,
//                                   plus misaligned_o for the request.
//   ld_funct3_i/ld_off_i/ld_rdata_i : latched load info and raw memory word
//                                   -> shifted and extended ld_data_o.
module mem_align
  import rv32_mem_pkg::*;
(
  input  logic [1:0]  st_size_i,
  input  logic [1:0]  st_off_i,
  input  logic [31:0] st_wdata_i,
  output logic [31:0] st_wdata_o,
  output logic [3:0]  st_wmask_o,
  output logic        misaligned_o,
  input  logic [2:0]  ld_funct3_i,
  input  logic [1:0]  ld_off_i,
  input  logic [31:0] ld_rdata_i,
  output logic [31:0] ld_data_o
);

  logic [31:0] shifted;

  always_comb begin
    case (st_size_i)
      2'b00: begin
        st_wdata_o = {4{st_wdata_i[7:0]}};
        st_wmask_o = 4'b0001 << st_off_i;
      end
      2'b01: begin
        st_wdata_o = {2{st_wdata_i[15:0]}};
        st_wmask_o = 4'b0011 << st_off_i;
      end
      default: begin
        st_wdata_o = st_wdata_i;
        st_wmask_o = 4'b1111;
      end
    endcase
    misaligned_o = addr_misaligned(st_size_i, st_off_i);
  end

  always_comb begin
    shifted = ld_rdata_i >> {ld_off_i, 3'b000};
    case (ld_funct3_i)
      F3_B:    ld_data_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   ld_data_o = {24'h000000, shifted[7:0]};
      F3_H:    ld_data_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   ld_data_o = {16'h0000, shifted[15:0]};
      default: ld_data_o = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Initiator-side load/store unit for the RV32 data-memory bus.
//   clk, reset (sync, active-low)
//   req_*  : one request at a time over valid/ready
//   resp_* : single-cycle completion pulse with extended load data / error
//   mem_*  : word-aligned bus with one-cycle read strobe / write mask and
//            busy handshakes for completion
// All outputs are registered; next values are derived from the next state.
module mem_access_unit
  import rv32_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 0,
  parameter int unsigned TO_WIDTH       = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  output logic        mem_rstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rbusy,
  input  logic        mem_wbusy
);

  localparam logic [TO_WIDTH:0] TO_LIMIT = (TO_WIDTH + 1)'(TIMEOUT_CYCLES);

  state_e state_q, state_d;
  logic                we_q, we_d;
  logic [2:0]          f3_q, f3_d;
  logic [1:0]          off_q, off_d;
  logic [TO_WIDTH-1:0] cnt_q, cnt_d;
  logic [TO_WIDTH:0]   cnt_inc;

  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_wmask_q, mem_wmask_d;
  logic        mem_rstrb_q, mem_rstrb_d;

  logic [31:0] st_wdata;
  logic [3:0]  st_wmask;
  logic        misaligned;
  logic [31:0] ld_data;
  logic        busy;

  mem_align u_align (
    .st_size_i    (req_funct3[1:0]),
    .st_off_i     (req_addr[1:0]),
    .st_wdata_i   (req_wdata),
    .st_wdata_o   (st_wdata),
    .st_wmask_o   (st_wmask),
    .misaligned_o (misaligned),
    .ld_funct3_i  (f3_q),
    .ld_off_i     (off_q),
    .ld_rdata_i   (mem_rdata),
    .ld_data_o    (ld_data)
  );

  assign busy    = we_q ? mem_wbusy : mem_rbusy;
  assign cnt_inc = {1'b0, cnt_q} + 1'b1;

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    f3_d         = f3_q;
    off_d        = off_q;
    cnt_d        = cnt_q;
    req_ready_d  = 1'b0;
    resp_valid_d = 1'b0;
    resp_rdata_d = '0;
    resp_err_d   = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wmask_d  = '0;
    mem_rstrb_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // req_ready_q is low for the first cycle out of reset, so no
        // handshake can complete then.
        if (req_valid && req_ready_q) begin
          we_d  = req_we;
          f3_d  = req_funct3;
          off_d = req_addr[1:0];
          if (!f3_legal(req_we, req_funct3) || misaligned) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            state_d    = ST_ISSUE;
            cnt_d      = '0;
            mem_addr_d = {req_addr[31:2], 2'b00};
            if (req_we) begin
              mem_wmask_d = st_wmask;
              mem_wdata_d = st_wdata;
            end else begin
              mem_rstrb_d = 1'b1;
            end
          end
        end else begin
          req_ready_d = 1'b1;
        end
      end

      ST_ISSUE: state_d = ST_WAIT;

      ST_WAIT: begin
        if (!busy) begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          if (!we_q) resp_rdata_d = ld_data;
        end else begin
          // Saturating count of busy cycles; the timeout compares the
          // post-increment value so exactly TIMEOUT_CYCLES busy cycles pass.
          if (!cnt_inc[TO_WIDTH]) cnt_d = cnt_inc[TO_WIDTH-1:0];
          if ((TIMEOUT_CYCLES != 0) && (cnt_inc >= TO_LIMIT)) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end
        end
      end

      ST_RESP: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      we_q         <= 1'b0;
      f3_q         <= '0;
      off_q        <= '0;
      cnt_q        <= '0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wmask_q  <= '0;
      mem_rstrb_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      f3_q         <= f3_d;
      off_q        <= off_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wmask_q  <= mem_wmask_d;
      mem_rstrb_q  <= mem_rstrb_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_wmask  = mem_wmask_q;
  assign mem_rstrb  = mem_rstrb_q;

endmodule
